life_draw_ctrl: RTL and testbench
=================================

Name: life_draw_ctrl

Overview:
- Sequencer for the Game of Life board-draw datapath.
- Walks the board row by row and column by column.
  - Per row: fetches the row's 40-bit data word from board memory.
  - Per cell: pulses the datapath load strobes (ld_x/ld_y/ld_c), then enables the datapath's 4x4 pixel counter for 16 plot cycles.
- Clears the life score at the start of each frame and signals frame completion.
- Sits between the top-level frame tick (start) and the datapath/VGA plot path.

Parameters:
- COLS, 40, cells per row; legal range 1..40, bounded by the 40-bit row word.
- ROWS, 30, rows per frame; legal range 1..32, bounded by the 5-bit row select.
- BLOCK_PIX, 16, plot cycles per cell (4x4 block).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  single-cycle frame request; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE completes
- done  out  1  one-cycle pulse at frame end
- row_rd_req  out  1  row fetch request; held high until acknowledged
- row_rd_ack  in  1  memory has row data valid on the datapath data bus
- row_sel  out  5  row index; drives datapath register input and memory address
- col_addr  out  6  column index; drives datapath addr input
- ld_x  out  1  datapath x load strobe
- ld_y  out  1  datapath y load strobe
- ld_c  out  1  datapath colour load strobe
- enable  out  1  datapath pixel-counter enable
- plot  out  1  VGA write strobe; equals enable
- reset_score_n  out  1  active-low life-score clear to the datapath

Behaviour:
- Reset (any cycle, including mid-frame):
  - Next state IDLE.
  - busy=0, done=0, row_rd_req=0, ld_*=0, enable=plot=0.
  - row_sel=0, col_addr=0, reset_score_n=1.
  - An in-flight fetch is dropped; a late row_rd_ack is ignored.
- States: IDLE, CLR, FETCH, LOAD, DRAW, NEXT, DONE.
- IDLE:
  - start=1 -> CLR; row=0, col=0. start=0 -> stay in IDLE.
  - start while not in IDLE is ignored; no queuing.
- CLR (1 cycle): reset_score_n=0; -> FETCH.
- FETCH:
  - row_rd_req=1.
  - When row_rd_ack is sampled 1 -> LOAD next cycle; otherwise stay.
  - Memory must hold data stable until the row is finished.
  - Ack tied high gives exactly 1 FETCH cycle per row.
- LOAD (1 cycle):
  - ld_x=ld_y=ld_c=1.
  - The datapath's pixel counter is cleared by the load strobes.
  - The life score increments once per cell when the cell's bit is set.
  - Next state DRAW; internal pixel count = 0.
- DRAW (BLOCK_PIX cycles):
  - enable=plot=1.
  - Pixel count 0..BLOCK_PIX-1; at BLOCK_PIX-1 -> NEXT.
- NEXT (1 cycle), all strobes 0:
  - col<COLS-1: col+1 -> LOAD.
  - col==COLS-1 and row<ROWS-1: col=0, row+1 -> FETCH.
  - col==COLS-1 and row==ROWS-1 -> DONE.
- DONE (1 cycle):
  - done=1, busy still 1; -> IDLE.
  - start asserted in this cycle is ignored.
- row_sel/col_addr:
  - Registered; stable throughout LOAD and DRAW of a cell.
  - Hold their last values in IDLE after a frame.
- Timing:
  - Cycles per cell = 1 + BLOCK_PIX + 1 = 18.
  - Frame length with zero-wait ack = 1 (CLR) + ROWS*(1 + COLS*18) + 1 (DONE), counted from the first cycle after start is accepted.
- Counter widths: row 5 bits, col 6 bits, pixel 5 bits. No wrap beyond the parameter limits.

Decomposition:
- Shared package life_draw_pkg:
  - state enum.
  - ROW_W=5, COL_W=6, PIX_W=5.
  - Default COLS/ROWS/BLOCK_PIX constants.
- No sub-module: the three counters and the FSM are inline in life_draw_ctrl. A split is not warranted at this size.

Test Plan:
- ROWS=2, COLS=2, ack tied 1; start pulse:
  - busy rises next cycle.
  - done pulses 76 cycles after start is sampled.
  - Exactly 4 LOAD pulses and 64 plot cycles.
- Same configuration, cell order check: (row_sel,col_addr) during LOAD is (0,0),(0,1),(1,0),(1,1). reset_score_n is low exactly 1 cycle, before the first FETCH.
- Ack delayed 3 cycles on each row:
  - row_rd_req held 4 cycles per row.
  - No ld_*/enable while waiting.
  - Frame length grows by 3*ROWS.
- start held high continuously:
  - After DONE, one IDLE cycle, then a new frame begins.
  - start pulses during a frame have no effect on counters.
- reset_n=0 for 1 cycle mid-DRAW at row 1, col 5:
  - Next cycle all outputs are at reset values and state is IDLE.
  - A subsequent start redraws from (0,0).
- Defaults (ROWS=30, COLS=40), ack=1: done arrives 21632 cycles after start. The last LOAD shows row_sel=29, col_addr=39.

Source files
------------

// File: rtl/life_draw_pkg.sv
// Shared types and sizing for the Game of Life board-draw sequencer.
package life_draw_pkg;

  localparam int ROW_W = 5;
  localparam int COL_W = 6;
  localparam int PIX_W = 5;

  localparam int DEF_COLS      = 40;
  localparam int DEF_ROWS      = 30;
  localparam int DEF_BLOCK_PIX = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_LOAD,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

endpackage

// File: rtl/life_draw_ctrl.sv
// Board-draw sequencer: fetches each row word, then loads and plots every cell
// as a 4x4 block. Counters and FSM live in one always_ff with registered outputs.
//
// state | meaning
// IDLE  | waiting for start; row/col hold the last frame's final cell
// CLR   | one cycle of life-score clear
// FETCH | row fetch request held until the memory acknowledges
// LOAD  | one cycle of datapath load strobes for the current cell
// DRAW  | BLOCK_PIX cycles of pixel-counter enable / plot
// NEXT  | advance column, row, or finish
// DONE  | one-cycle frame-complete pulse
module life_draw_ctrl
  import life_draw_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int BLOCK_PIX = DEF_BLOCK_PIX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             row_rd_req,
  input  logic             row_rd_ack,
  output logic [ROW_W-1:0] row_sel,
  output logic [COL_W-1:0] col_addr,
  output logic             ld_x,
  output logic             ld_y,
  output logic             ld_c,
  output logic             enable,
  output logic             plot,
  output logic             reset_score_n
);

  state_t           state;
  logic [PIX_W-1:0] pix;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(BLOCK_PIX - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      pix           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      row_rd_req    <= 1'b0;
      row_sel       <= '0;
      col_addr      <= '0;
      ld_x          <= 1'b0;
      ld_y          <= 1'b0;
      ld_c          <= 1'b0;
      enable        <= 1'b0;
      plot          <= 1'b0;
      reset_score_n <= 1'b1;
    end else begin
      // Strobes are pulses; each transition below re-asserts what the next state needs.
      done          <= 1'b0;
      ld_x          <= 1'b0;
      ld_y          <= 1'b0;
      ld_c          <= 1'b0;
      enable        <= 1'b0;
      plot          <= 1'b0;
      reset_score_n <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_CLR;
            busy          <= 1'b1;
            reset_score_n <= 1'b0;
            row_sel       <= '0;
            col_addr      <= '0;
          end
        end

        S_CLR: begin
          state      <= S_FETCH;
          row_rd_req <= 1'b1;
        end

        S_FETCH: begin
          if (row_rd_ack) begin
            state      <= S_LOAD;
            row_rd_req <= 1'b0;
            ld_x       <= 1'b1;
            ld_y       <= 1'b1;
            ld_c       <= 1'b1;
          end
        end

        S_LOAD: begin
          state  <= S_DRAW;
          pix    <= '0;
          enable <= 1'b1;
          plot   <= 1'b1;
        end

        S_DRAW: begin
          if (pix == PIX_LAST) begin
            state <= S_NEXT;
          end else begin
            pix    <= pix + 1'b1;
            enable <= 1'b1;
            plot   <= 1'b1;
          end
        end

        S_NEXT: begin
          if (col_addr != COL_LAST) begin
            state    <= S_LOAD;
            col_addr <= col_addr + 1'b1;
            ld_x     <= 1'b1;
            ld_y     <= 1'b1;
            ld_c     <= 1'b1;
          end else if (row_sel != ROW_LAST) begin
            state      <= S_FETCH;
            col_addr   <= '0;
            row_sel    <= row_sel + 1'b1;
            row_rd_req <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          row_rd_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_draw_ctrl.sv
// Directed bench for life_draw_ctrl: a 2x2 instance for protocol/timing and a
// default-size instance for mid-frame reset and full-frame timing.
module tb_life_draw_ctrl;
  import life_draw_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int row;
    int col;
  } cell_t;

  cell_t q_s[$];
  cell_t q_d[$];

  // small instance
  logic       s_rst_n, s_start, s_ack, s_busy, s_done, s_req;
  logic [4:0] s_row;
  logic [5:0] s_col;
  logic       s_ldx, s_ldy, s_ldc, s_en, s_plot, s_rsn;
  logic       s_ack_delay, s_ack_r;
  assign s_ack = s_ack_delay ? s_ack_r : 1'b1;

  // default instance
  logic       d_rst_n, d_start, d_ack, d_busy, d_done, d_req;
  logic [4:0] d_row;
  logic [5:0] d_col;
  logic       d_ldx, d_ldy, d_ldc, d_en, d_plot, d_rsn;
  assign d_ack = 1'b1;

  life_draw_ctrl #(.COLS(2), .ROWS(2), .BLOCK_PIX(16)) dut_s (
    .clk(clk), .reset_n(s_rst_n), .start(s_start), .busy(s_busy), .done(s_done),
    .row_rd_req(s_req), .row_rd_ack(s_ack), .row_sel(s_row), .col_addr(s_col),
    .ld_x(s_ldx), .ld_y(s_ldy), .ld_c(s_ldc), .enable(s_en), .plot(s_plot),
    .reset_score_n(s_rsn)
  );

  life_draw_ctrl dut_d (
    .clk(clk), .reset_n(d_rst_n), .start(d_start), .busy(d_busy), .done(d_done),
    .row_rd_req(d_req), .row_rd_ack(d_ack), .row_sel(d_row), .col_addr(d_col),
    .ld_x(d_ldx), .ld_y(d_ldy), .ld_c(d_ldc), .enable(d_en), .plot(d_plot),
    .reset_score_n(d_rsn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int s_cyc, s_loads, s_plots, s_busy_cyc, s_rsn_low, s_rsn_at, s_req_first, s_req_cyc, s_bad, s_run;
  int d_loads, d_plots, d_last_row, d_last_col, d_bad;

  task automatic clr_s();
    s_cyc = 0; s_loads = 0; s_plots = 0; s_busy_cyc = 0; s_rsn_low = 0;
    s_rsn_at = -1; s_req_first = -1; s_req_cyc = 0; s_bad = 0;
    q_s.delete();
  endtask

  task automatic clr_d();
    d_loads = 0; d_plots = 0; d_last_row = -1; d_last_col = -1; d_bad = 0;
    q_d.delete();
  endtask

  task automatic push_s_frame();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) q_s.push_back(cell_t'{r, c});
  endtask

  // Monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cell_t e;
    s_cyc++;
    if (s_busy) s_busy_cyc++;
    if (s_ldx) begin
      s_loads++;
      e = (q_s.size() != 0) ? q_s.pop_front() : cell_t'{-1, -1};
      chk("s_load_row", s_row, e.row);
      chk("s_load_col", s_col, e.col);
      if (!(s_ldy && s_ldc)) s_bad++;
    end
    if (s_plot) s_plots++;
    if (s_plot !== s_en) s_bad++;
    if (!s_rsn) begin
      s_rsn_low++;
      s_rsn_at = s_cyc;
    end
    if (s_req) begin
      s_req_cyc++;
      if (s_req_first < 0) s_req_first = s_cyc;
      if (s_ldx || s_ldy || s_ldc || s_en) s_bad++;
    end
    if (s_req && s_ack_delay) begin
      if (s_run == 3) s_ack_r = 1'b1;
      s_run++;
    end else begin
      s_run   = 0;
      s_ack_r = 1'b0;
    end
  end

  always @(negedge clk) begin
    cell_t e;
    if (d_ldx) begin
      d_loads++;
      d_last_row = int'(d_row);
      d_last_col = int'(d_col);
      e = (q_d.size() != 0) ? q_d.pop_front() : cell_t'{-1, -1};
      if (d_row !== e.row[4:0] || d_col !== e.col[5:0]) d_bad++;
    end
    if (d_plot) d_plots++;
    if (d_plot !== d_en) d_bad++;
  end

  // Counts the cycle already in progress as 1; returns -1 if limit expires.
  task automatic wait_done(input bit use_d, input int limit, output int cyc);
    cyc = 1;
    while (!(use_d ? d_done : s_done)) begin
      if (cyc >= limit) begin
        cyc = -1;
        return;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    bit found;
    s_rst_n = 1'b0; d_rst_n = 1'b0; s_start = 1'b0; d_start = 1'b0;
    s_ack_delay = 1'b0; s_ack_r = 1'b0; s_run = 0;
    clr_s(); clr_d();
    repeat (3) @(negedge clk);

    chk("rst_ctrl", {s_busy, s_done, s_req, s_ldx, s_ldy, s_ldc, s_en, s_plot}, 0);
    chk("rst_row", s_row, 0);
    chk("rst_col", s_col, 0);
    chk("rst_score_n", s_rsn, 1);
    s_rst_n = 1'b1; d_rst_n = 1'b1;
    @(negedge clk);

    // 2x2 frame, ack tied high
    clr_s(); push_s_frame();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("t1_busy_rise", s_busy, 1);
    wait_done(1'b0, 200, cyc);
    chk("t1_done_cycle", cyc, 76);
    @(negedge clk);
    chk("t1_done_pulse", {s_done, s_busy}, 0);
    chk("t1_loads", s_loads, 4);
    chk("t1_plots", s_plots, 64);
    chk("t1_busy_cycles", s_busy_cyc, 76);
    chk("t1_score_clr_len", s_rsn_low, 1);
    chk("t1_clr_then_fetch", s_req_first - s_rsn_at, 1);
    chk("t1_req_cycles", s_req_cyc, 2);
    chk("t1_protocol", s_bad, 0);
    chk("t1_queue_left", q_s.size(), 0);
    chk("t1_hold_pos", {s_row, s_col}, {5'd1, 6'd1});

    // ack delayed 3 cycles per row
    clr_s(); push_s_frame();
    s_ack_delay = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    wait_done(1'b0, 300, cyc);
    chk("t2_done_cycle", cyc, 82);
    @(negedge clk);
    chk("t2_req_cycles", s_req_cyc, 8);
    chk("t2_loads", s_loads, 4);
    chk("t2_protocol", s_bad, 0);
    chk("t2_queue_left", q_s.size(), 0);
    s_ack_delay = 1'b0;

    // start held high across two frames
    clr_s(); push_s_frame(); push_s_frame();
    s_start = 1'b1;
    @(negedge clk);
    chk("t3_busy_rise", s_busy, 1);
    wait_done(1'b0, 200, cyc);
    chk("t3_done_cycle", cyc, 76);
    @(negedge clk);
    chk("t3_idle_gap", s_busy, 0);
    @(negedge clk);
    chk("t3_restart_busy", s_busy, 1);
    chk("t3_restart_clr", s_rsn, 0);
    s_start = 1'b0;
    wait_done(1'b0, 200, cyc);
    chk("t3_done2_cycle", cyc, 76);
    @(negedge clk);
    chk("t3_loads", s_loads, 8);
    chk("t3_queue_left", q_s.size(), 0);

    // default size: reset mid-DRAW at row 1, col 5
    clr_d();
    for (int c = 0; c < 40; c++) q_d.push_back(cell_t'{0, c});
    for (int c = 0; c < 6; c++) q_d.push_back(cell_t'{1, c});
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (d_en && d_row == 5'd1 && d_col == 6'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("t4_reach_draw", found, 1);
    d_rst_n = 1'b0;
    @(negedge clk);
    d_rst_n = 1'b1;
    chk("t4_rst_ctrl", {d_busy, d_done, d_req, d_ldx, d_ldy, d_ldc, d_en, d_plot}, 0);
    chk("t4_rst_pos", {d_row, d_col}, 0);
    chk("t4_rst_score_n", d_rsn, 1);
    repeat (3) @(negedge clk);
    chk("t4_stay_idle", {d_busy, d_req, d_ldx, d_en}, 0);
    chk("t4_abort_queue", q_d.size(), 0);
    chk("t4_abort_protocol", d_bad, 0);

    // full default frame after the abort
    clr_d();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++) q_d.push_back(cell_t'{r, c});
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    wait_done(1'b1, 30000, cyc);
    chk("t5_done_cycle", cyc, 21632);
    @(negedge clk);
    chk("t5_loads", d_loads, 1200);
    chk("t5_plots", d_plots, 19200);
    chk("t5_last_row", d_last_row, 29);
    chk("t5_last_col", d_last_col, 39);
    chk("t5_order", d_bad, 0);
    chk("t5_queue_left", q_d.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
